// File: rtl/wb_bram_arbiter.sv
// wb_bram_arbiter: shares one pipelined Wishbone slave between two masters, routing in-order acks via an ID FIFO.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module wb_bram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_L = 4,
  parameter int MAX_OUT = 4,
  localparam int DATA_W = DATA_L*8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_stb,
  input  logic              m1_stb,
  output logic              m0_stall,
  output logic              m1_stall,
  output logic              m0_ack,
  output logic              m1_ack,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m0_dat_w,
  input  logic [DATA_W-1:0] m1_dat_w,
  output logic [DATA_W-1:0] m0_dat_r,
  output logic [DATA_W-1:0] m1_dat_r,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [DATA_L-1:0] m0_sel,
  input  logic [DATA_L-1:0] m1_sel,
  output logic              s_stb,
  input  logic              s_stall,
  input  logic              s_ack,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_w,
  output logic              s_we,
  output logic [DATA_L-1:0] s_sel,
  input  logic [DATA_W-1:0] s_dat_r
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [MAX_OUT-1:0] ids_q, ids_d;
  logic gnt1, full, issue, ack_v;
`ifdef WB_ARB_RR_EN
  logic last_q, last_d;
  always_comb gnt1 = m1_stb & (!m0_stb | !last_q);
  always_comb last_d = issue ? gnt1 : last_q;
  always_ff @(posedge clk) last_q <= rst ? 1'b1 : last_d;
`else
  always_comb gnt1 = m1_stb & !m0_stb;
`endif
  always_comb begin
    full = cnt_q == CW'(MAX_OUT);
    s_stb = (m0_stb | m1_stb) & !full;
    issue = s_stb & !s_stall;
    ack_v = s_ack & (cnt_q != '0);
    s_adr = gnt1 ? m1_adr : m0_adr;
    s_dat_w = gnt1 ? m1_dat_w : m0_dat_w;
    s_we = gnt1 ? m1_we : m0_we;
    s_sel = gnt1 ? m1_sel : m0_sel;
    m0_stall = m0_stb & (gnt1 | s_stall | full);
    m1_stall = m1_stb & (!gnt1 | s_stall | full);
    m0_ack = ack_v & !ids_q[rp_q];
    m1_ack = ack_v & ids_q[rp_q];
    m0_dat_r = s_dat_r;
    m1_dat_r = s_dat_r;
    ids_d = ids_q;
    if (issue) ids_d[wp_q] = gnt1;
    wp_d = issue ? wp_q + PW'(1) : wp_q;
    rp_d = ack_v ? rp_q + PW'(1) : rp_q;
    cnt_d = cnt_q + CW'(issue) - CW'(ack_v);
  end
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
    wp_q <= rst ? '0 : wp_d;
    rp_q <= rst ? '0 : rp_d;
    ids_q <= rst ? '0 : ids_d;
  end
endmodule

// File: tb/tb_wb_bram_arbiter.sv
// tb_wb_bram_arbiter: random two-master traffic against a queue-based model; acks checked by a scoreboard monitor.
module tb_wb_bram_arbiter;
  localparam int AW = 32, DL = 4, DW = 32, MO = 4;
`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic m0_stb, m1_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_we, m1_we;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
  logic [DL-1:0] m0_sel, m1_sel, s_sel;
  logic s_stb, s_stall, s_ack, s_we;
  int cmp = 0, err = 0;
  bit mq[$];
  bit last_m = 1'b1;
  logic [DW:0] sb[$];
  logic [DW:0] mon_e;
  bit mon_ex;

  always #5 clk = ~clk;

  wb_bram_arbiter #(.ADDR_W(AW), .DATA_L(DL), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m1_stb(m1_stb), .m0_stall(m0_stall), .m1_stall(m1_stall),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_adr(m0_adr), .m1_adr(m1_adr),
    .m0_dat_w(m0_dat_w), .m1_dat_w(m1_dat_w), .m0_dat_r(m0_dat_r), .m1_dat_r(m1_dat_r),
    .m0_we(m0_we), .m1_we(m1_we), .m0_sel(m0_sel), .m1_sel(m1_sel),
    .s_stb(s_stb), .s_stall(s_stall), .s_ack(s_ack), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_we(s_we), .s_sel(s_sel), .s_dat_r(s_dat_r)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Any cycle where an ack is expected or seen, the head of the scoreboard must match.
  always @(negedge clk) begin
    if (m0_ack || m1_ack || sb.size() != 0) begin
      mon_ex = sb.size() != 0;
      mon_e = mon_ex ? sb.pop_front() : '0;
      chk("ack_route", 64'({m1_ack, m0_ack}), mon_ex ? (mon_e[DW] ? 64'd2 : 64'd1) : 64'd0);
      if (mon_ex) chk("ack_data", 64'(mon_e[DW] ? m1_dat_r : m0_dat_r), 64'(mon_e[DW-1:0]));
    end
  end

  task automatic step(input int sp, input int stp, input int ap);
    bit g, full, req, iss;
    @(posedge clk); #1;
    m0_stb = $urandom_range(99) < sp;
    m1_stb = $urandom_range(99) < sp;
    m0_adr = $urandom; m1_adr = $urandom;
    m0_dat_w = $urandom; m1_dat_w = $urandom;
    m0_we = 1'($urandom); m1_we = 1'($urandom);
    m0_sel = DL'($urandom); m1_sel = DL'($urandom);
    s_stall = $urandom_range(99) < stp;
    s_ack = $urandom_range(99) < ap;
    s_dat_r = $urandom;
    #1;
    req = m0_stb || m1_stb;
    g = (m0_stb && m1_stb) ? (RR ? !last_m : 1'b0) : m1_stb;
    full = mq.size() == MO;
    chk("s_stb", 64'(s_stb), 64'(req && !full));
    chk("s_adr", 64'(s_adr), 64'(g ? m1_adr : m0_adr));
    chk("s_dat_w", 64'(s_dat_w), 64'(g ? m1_dat_w : m0_dat_w));
    chk("s_we_sel", 64'({s_we, s_sel}), 64'(g ? {m1_we, m1_sel} : {m0_we, m0_sel}));
    chk("m0_stall", 64'(m0_stall), 64'(m0_stb ? (g ? 1'b1 : (s_stall || full)) : 1'b0));
    chk("m1_stall", 64'(m1_stall), 64'(m1_stb ? (g ? (s_stall || full) : 1'b1) : 1'b0));
    iss = req && !full && !s_stall;
    if (s_ack && mq.size() != 0) sb.push_back({mq.pop_front(), s_dat_r});
    if (iss) begin
      mq.push_back(g);
      last_m = g;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    m0_stb = 0; m1_stb = 0; s_ack = 0; s_stall = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; s_ack = 1;
    mq.delete();
    last_m = 1'b1;
    #1;
    chk("post_rst_ack", 64'({m1_ack, m0_ack}), 64'd0);
    chk("post_rst_s_stb", 64'(s_stb), 64'd0);
  endtask

  initial begin
    int sp = 80, stp = 0, ap = 50;
    m0_stb = 0; m1_stb = 0; m0_we = 0; m1_we = 0; s_stall = 0; s_ack = 0;
    m0_adr = '0; m1_adr = '0; m0_dat_w = '0; m1_dat_w = '0; m0_sel = '0; m1_sel = '0; s_dat_r = '0;
    repeat (2) @(posedge clk);
    #1; rst = 0; s_ack = 1; #1;
    chk("rst_s_stb", 64'(s_stb), 64'd0);
    chk("rst_acks", 64'({m1_ack, m0_ack}), 64'd0);
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) begin
        sp = ($urandom_range(1) != 0) ? 90 : 35;
        stp = $urandom_range(2) * 25;
        ap = ($urandom_range(2) == 0) ? 0 : (($urandom_range(1) != 0) ? 40 : 95);
      end
      if (c == 1500) begin
        step(100, 0, 0);
        step(100, 0, 0);
        do_reset();
      end else step(sp, stp, ap);
    end
    for (int i = 0; i < 4 * MO && mq.size() != 0; i++) step(0, 0, 100);
    @(posedge clk); #1;
    m0_stb = 0; m1_stb = 0; s_ack = 1; #1;
    chk("drain_no_ack", 64'({m1_ack, m0_ack}), 64'd0);
    @(negedge clk); #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
